ps2_mouse_packet: RTL and testbench

Packet assembler and cursor tracker for a PS/2 mouse in stream mode. It sits directly downstream of the PS/2 receiver and consumes its `rx_done_tick` / `dout` byte stream. It groups bytes into standard 3-byte mouse packets, checks framing, and decodes buttons and signed 9-bit deltas. It also maintains a clamped absolute cursor position for the display logic.

---
 rtl/ps2_mouse_pkg.sv | 29 ++
 rtl/ps2_pos_clamp.sv | 45 ++++
 rtl/ps2_mouse_packet.sv | 210 +++++++++++++++++++++
 tb/tb_ps2_mouse_packet.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/ps2_mouse_pkg.sv
// Shared encodings for the PS/2 mouse packet assembler.
// PS2_MOUSE_WHEEL_EN selects 4-byte IntelliMouse packets.
package ps2_mouse_pkg;

`ifdef PS2_MOUSE_WHEEL_EN
  typedef enum logic [1:0] {
    WAIT_B0 = 2'd0,
    WAIT_B1 = 2'd1,
    WAIT_B2 = 2'd2,
    WAIT_B3 = 2'd3
  } ps2_state_e;
  localparam int unsigned PKT_BYTES = 4;
`else
  typedef enum logic [1:0] {
    WAIT_B0 = 2'd0,
    WAIT_B1 = 2'd1,
    WAIT_B2 = 2'd2
  } ps2_state_e;
  localparam int unsigned PKT_BYTES = 3;
`endif

  // Bit positions inside the first (status) byte of a packet
  localparam int unsigned SYNC_BIT = 3;
  localparam int unsigned XS_BIT   = 4;
  localparam int unsigned YS_BIT   = 5;
  localparam int unsigned XOVF_BIT = 6;
  localparam int unsigned YOVF_BIT = 7;

endpackage

// File: rtl/ps2_pos_clamp.sv
// Single-axis cursor accumulator: signed add, clamp to [0, MAX], hold when the
// packet flags overflow on this axis.
module ps2_pos_clamp #(
  parameter int unsigned POS_W = 10,
  parameter int unsigned MAX   = 639
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              upd,
  input  logic              hold,
  input  logic signed [9:0] delta,
  output logic [POS_W-1:0]  pos
);

  localparam int unsigned SUM_W = POS_W + 2;

  logic [POS_W-1:0]        pos_q;
  logic [POS_W-1:0]        pos_d;
  logic signed [SUM_W-1:0] sum_c;

  always_comb begin
    sum_c = $signed({2'b00, pos_q}) + SUM_W'(delta);
    pos_d = pos_q;
    if (upd && !hold) begin
      if (sum_c[SUM_W-1]) begin
        pos_d = '0;
      end else if (sum_c > $signed(SUM_W'(MAX))) begin
        pos_d = POS_W'(MAX);
      end else begin
        pos_d = sum_c[POS_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pos_q <= POS_W'(MAX / 2);
    end else begin
      pos_q <= pos_d;
    end
  end

  assign pos = pos_q;

endmodule

// File: rtl/ps2_mouse_packet.sv
// PS/2 stream-mode packet assembler with framing check, timeout resync and a
// clamped absolute cursor. PS2_MOUSE_WHEEL_EN adds the 4th (wheel) byte and dz.
module ps2_mouse_packet
  import ps2_mouse_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
  parameter int unsigned POS_W          = 10,
  parameter int unsigned X_MAX          = 639,
  parameter int unsigned Y_MAX          = 479
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_done_tick,
  input  logic [7:0]       rx_data,
  output logic             pkt_valid,
  output logic [2:0]       btn,
  output logic [8:0]       dx,
  output logic [8:0]       dy,
`ifdef PS2_MOUSE_WHEEL_EN
  output logic [3:0]       dz,
`endif
  output logic             x_ovf,
  output logic             y_ovf,
  output logic [POS_W-1:0] x_pos,
  output logic [POS_W-1:0] y_pos,
  output logic             sync_err,
  output logic             timeout
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  ps2_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0] b0_q, b0_d;
  logic [7:0] b1_q, b1_d;
  logic       pkt_valid_q, pkt_valid_d;
  logic       sync_err_q, sync_err_d;
  logic       timeout_q, timeout_d;
  logic [2:0] btn_q, btn_d;
  logic [8:0] dx_q, dx_d;
  logic [8:0] dy_q, dy_d;
  logic       x_ovf_q, x_ovf_d;
  logic       y_ovf_q, y_ovf_d;
`ifdef PS2_MOUSE_WHEEL_EN
  logic [7:0] b2_q, b2_d;
  logic [3:0] dz_q, dz_d;
`endif

  logic              terminal_c;
  logic              pkt_done_c;
  logic [8:0]        dx_new_c;
  logic [8:0]        dy_new_c;
  logic signed [9:0] dx_delta_c;
  logic signed [9:0] dy_delta_c;

  // Deltas of the packet completing this cycle (valid only with pkt_done_c)
  assign dx_new_c = {b0_q[XS_BIT], b1_q};
`ifdef PS2_MOUSE_WHEEL_EN
  assign dy_new_c = {b0_q[YS_BIT], b2_q};
`else
  assign dy_new_c = {b0_q[YS_BIT], rx_data};
`endif
  assign dx_delta_c = $signed({dx_new_c[8], dx_new_c});
  // PS/2 y grows upward, screen y grows downward
  assign dy_delta_c = -$signed({dy_new_c[8], dy_new_c});
  assign terminal_c = (cnt_q == CNT_W'(TIMEOUT_CYCLES));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    b0_d        = b0_q;
    b1_d        = b1_q;
    pkt_valid_d = 1'b0;
    sync_err_d  = 1'b0;
    timeout_d   = 1'b0;
    btn_d       = btn_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    x_ovf_d     = x_ovf_q;
    y_ovf_d     = y_ovf_q;
    pkt_done_c  = 1'b0;
`ifdef PS2_MOUSE_WHEEL_EN
    b2_d        = b2_q;
    dz_d        = dz_q;
`endif

    // Inter-byte watchdog; an arriving byte always beats the terminal count
    if (state_q == WAIT_B0 || rx_done_tick) begin
      cnt_d = '0;
    end else if (terminal_c) begin
      cnt_d     = '0;
      timeout_d = 1'b1;
      state_d   = WAIT_B0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (rx_done_tick) begin
      case (state_q)
        WAIT_B0: begin
          if (rx_data[SYNC_BIT]) begin
            b0_d    = rx_data;
            state_d = WAIT_B1;
          end else begin
            sync_err_d = 1'b1;
          end
        end
        WAIT_B1: begin
          b1_d    = rx_data;
          state_d = WAIT_B2;
        end
`ifdef PS2_MOUSE_WHEEL_EN
        WAIT_B2: begin
          b2_d    = rx_data;
          state_d = WAIT_B3;
        end
        WAIT_B3: begin
          pkt_done_c = 1'b1;
          dz_d       = rx_data[3:0];
          state_d    = WAIT_B0;
        end
`else
        WAIT_B2: begin
          pkt_done_c = 1'b1;
          state_d    = WAIT_B0;
        end
`endif
        default: state_d = WAIT_B0;
      endcase
    end

    if (pkt_done_c) begin
      pkt_valid_d = 1'b1;
      btn_d       = b0_q[2:0];
      dx_d        = dx_new_c;
      dy_d        = dy_new_c;
      x_ovf_d     = b0_q[XOVF_BIT];
      y_ovf_d     = b0_q[YOVF_BIT];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= WAIT_B0;
      cnt_q       <= '0;
      b0_q        <= '0;
      b1_q        <= '0;
      pkt_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
      timeout_q   <= 1'b0;
      btn_q       <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
      x_ovf_q     <= 1'b0;
      y_ovf_q     <= 1'b0;
`ifdef PS2_MOUSE_WHEEL_EN
      b2_q        <= '0;
      dz_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      b0_q        <= b0_d;
      b1_q        <= b1_d;
      pkt_valid_q <= pkt_valid_d;
      sync_err_q  <= sync_err_d;
      timeout_q   <= timeout_d;
      btn_q       <= btn_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      x_ovf_q     <= x_ovf_d;
      y_ovf_q     <= y_ovf_d;
`ifdef PS2_MOUSE_WHEEL_EN
      b2_q        <= b2_d;
      dz_q        <= dz_d;
`endif
    end
  end

  ps2_pos_clamp #(.POS_W(POS_W), .MAX(X_MAX)) u_x_clamp (
    .clk   (clk),
    .rst   (rst),
    .upd   (pkt_done_c),
    .hold  (b0_q[XOVF_BIT]),
    .delta (dx_delta_c),
    .pos   (x_pos)
  );

  ps2_pos_clamp #(.POS_W(POS_W), .MAX(Y_MAX)) u_y_clamp (
    .clk   (clk),
    .rst   (rst),
    .upd   (pkt_done_c),
    .hold  (b0_q[YOVF_BIT]),
    .delta (dy_delta_c),
    .pos   (y_pos)
  );

  assign pkt_valid = pkt_valid_q;
  assign sync_err  = sync_err_q;
  assign timeout   = timeout_q;
  assign btn       = btn_q;
  assign dx        = dx_q;
  assign dy        = dy_q;
  assign x_ovf     = x_ovf_q;
  assign y_ovf     = y_ovf_q;
`ifdef PS2_MOUSE_WHEEL_EN
  assign dz        = dz_q;
`endif

endmodule

// File: tb/tb_ps2_mouse_packet.sv
// Directed self-checking bench for ps2_mouse_packet (both packet sizes).
module tb_ps2_mouse_packet;

  localparam int unsigned TO = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_done_tick;
  logic [7:0] rx_data;
  logic       pkt_valid;
  logic [2:0] btn;
  logic [8:0] dx;
  logic [8:0] dy;
`ifdef PS2_MOUSE_WHEEL_EN
  logic [3:0] dz;
`endif
  logic       x_ovf;
  logic       y_ovf;
  logic [9:0] x_pos;
  logic [9:0] y_pos;
  logic       sync_err;
  logic       timeout;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  ps2_mouse_packet #(
    .TIMEOUT_CYCLES (TO),
    .POS_W          (10),
    .X_MAX          (639),
    .Y_MAX          (479)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_done_tick (rx_done_tick),
    .rx_data      (rx_data),
    .pkt_valid    (pkt_valid),
    .btn          (btn),
    .dx           (dx),
    .dy           (dy),
`ifdef PS2_MOUSE_WHEEL_EN
    .dz           (dz),
`endif
    .x_ovf        (x_ovf),
    .y_ovf        (y_ovf),
    .x_pos        (x_pos),
    .y_pos        (y_pos),
    .sync_err     (sync_err),
    .timeout      (timeout)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // One strobe, then return at the negedge right after it was consumed
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_done_tick = 1'b1;
    rx_data      = b;
    @(negedge clk);
    rx_done_tick = 1'b0;
  endtask

  // Back-to-back packet; wheel builds append a zero wheel byte
  task automatic send_pkt(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    @(negedge clk);
    rx_done_tick = 1'b1;
    rx_data      = a;
    @(negedge clk);
    rx_data      = b;
    @(negedge clk);
    rx_data      = c;
`ifdef PS2_MOUSE_WHEEL_EN
    @(negedge clk);
    rx_data      = 8'h00;
`endif
    @(negedge clk);
    rx_done_tick = 1'b0;
  endtask

  initial begin
    rst          = 1'b0;
    rx_done_tick = 1'b0;
    rx_data      = 8'h00;
    repeat (3) @(negedge clk);
    check_eq("rst_pkt_valid", 32'(pkt_valid), 32'd0);
    check_eq("rst_sync_err", 32'(sync_err), 32'd0);
    check_eq("rst_timeout", 32'(timeout), 32'd0);
    check_eq("rst_btn", 32'(btn), 32'd0);
    check_eq("rst_dx", 32'(dx), 32'd0);
    check_eq("rst_x_ovf", 32'(x_ovf), 32'd0);
    check_eq("rst_x_pos", 32'(x_pos), 32'd319);
    check_eq("rst_y_pos", 32'(y_pos), 32'd239);
    rst = 1'b1;

    // Basic packet: left button, +5 right, +3 up
    send_pkt(8'h09, 8'h05, 8'h03);
    check_eq("p1_valid", 32'(pkt_valid), 32'd1);
    check_eq("p1_btn", 32'(btn), 32'd1);
    check_eq("p1_dx", 32'(dx), 32'd5);
    check_eq("p1_dy", 32'(dy), 32'd3);
    check_eq("p1_x_pos", 32'(x_pos), 32'd324);
    check_eq("p1_y_pos", 32'(y_pos), 32'd236);
    @(negedge clk);
    check_eq("p1_valid_pulse", 32'(pkt_valid), 32'd0);
    check_eq("p1_btn_held", 32'(btn), 32'd1);

    // Sync failure then negative deltas on both axes
    send_byte(8'h00);
    check_eq("sync_err_pulse", 32'(sync_err), 32'd1);
    check_eq("sync_no_valid", 32'(pkt_valid), 32'd0);
    @(negedge clk);
    check_eq("sync_err_clear", 32'(sync_err), 32'd0);
    send_pkt(8'h38, 8'hF0, 8'hF0);
    check_eq("p2_valid", 32'(pkt_valid), 32'd1);
    check_eq("p2_dx", 32'(dx), 32'h1F0);
    check_eq("p2_dy", 32'(dy), 32'h1F0);
    check_eq("p2_x_pos", 32'(x_pos), 32'd308);
    check_eq("p2_y_pos", 32'(y_pos), 32'd252);

    // Partial packet abandoned by the watchdog
    send_byte(8'h08);
    send_byte(8'h10);
    repeat (TO) @(negedge clk);
    check_eq("to_not_yet", 32'(timeout), 32'd0);
    @(negedge clk);
    check_eq("to_pulse", 32'(timeout), 32'd1);
    check_eq("to_no_valid", 32'(pkt_valid), 32'd0);
    send_pkt(8'h08, 8'h00, 8'h00);
    check_eq("p3_valid", 32'(pkt_valid), 32'd1);
    check_eq("p3_dx", 32'(dx), 32'd0);
    check_eq("p3_x_pos", 32'(x_pos), 32'd308);
    check_eq("p3_y_pos", 32'(y_pos), 32'd252);

    // X overflow packet; 2nd byte lands exactly on the terminal count
    send_byte(8'h48);
    repeat (TO - 1) @(negedge clk);
    send_byte(8'h7F);
    check_eq("term_no_timeout", 32'(timeout), 32'd0);
    send_byte(8'h01);
`ifdef PS2_MOUSE_WHEEL_EN
    send_byte(8'h00);
`endif
    check_eq("ovf_valid", 32'(pkt_valid), 32'd1);
    check_eq("ovf_flag", 32'(x_ovf), 32'd1);
    check_eq("ovf_dx_raw", 32'(dx), 32'h07F);
    check_eq("ovf_x_hold", 32'(x_pos), 32'd308);
    check_eq("ovf_y_pos", 32'(y_pos), 32'd251);

    // dy = -256 pushes y past the bottom edge
    send_pkt(8'h28, 8'h00, 8'h00);
    check_eq("ysat_dy", 32'(dy), 32'h100);
    check_eq("ysat_y_pos", 32'(y_pos), 32'd479);

    // X saturates high, then low
    send_pkt(8'h08, 8'h7F, 8'h00);
    check_eq("xhi_first", 32'(x_pos), 32'd435);
    for (int i = 0; i < 3; i++) send_pkt(8'h08, 8'h7F, 8'h00);
    check_eq("xhi_sat", 32'(x_pos), 32'd639);
    send_pkt(8'h18, 8'h80, 8'h00);
    check_eq("xlo_dx", 32'(dx), 32'h180);
    check_eq("xlo_first", 32'(x_pos), 32'd511);
    for (int i = 0; i < 5; i++) send_pkt(8'h18, 8'h80, 8'h00);
    check_eq("xlo_sat", 32'(x_pos), 32'd0);

`ifdef PS2_MOUSE_WHEEL_EN
    // Wheel byte completes the packet
    send_byte(8'h08);
    send_byte(8'h00);
    send_byte(8'h00);
    check_eq("whl_no_valid_b2", 32'(pkt_valid), 32'd0);
    send_byte(8'h0F);
    check_eq("whl_valid", 32'(pkt_valid), 32'd1);
    check_eq("whl_dz", 32'(dz), 32'hF);
`endif

    // Reset mid-packet discards partial bytes
    send_byte(8'h09);
    send_byte(8'h05);
    rst = 1'b0;
    @(negedge clk);
    check_eq("mrst_x_pos", 32'(x_pos), 32'd319);
    check_eq("mrst_y_pos", 32'(y_pos), 32'd239);
    check_eq("mrst_dx", 32'(dx), 32'd0);
    check_eq("mrst_dy", 32'(dy), 32'd0);
`ifdef PS2_MOUSE_WHEEL_EN
    check_eq("mrst_dz", 32'(dz), 32'd0);
`endif
    rst = 1'b1;
    send_byte(8'h05);
    check_eq("mrst_resync", 32'(sync_err), 32'd1);
    check_eq("mrst_no_valid", 32'(pkt_valid), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
